// File: rtl/ws2812_write_arbiter.sv
// ws2812_write_arbiter
//   Shares the single write port of a ws2812 driver between two valid/ready
//   requesters (A, B) and an internal fill engine that paints one colour into
//   every LED, one LED per cycle.
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_a_valid/o_a_ready     requester A handshake, i_a_led / i_a_rgb payload
//   i_b_valid/o_b_ready     requester B handshake, i_b_led / i_b_rgb payload
//   i_fill_start/i_fill_rgb fill request pulse and colour
//   o_fill_busy             fill engine owns the port
//   o_ws_write/o_ws_led_num/o_ws_rgb_data  driver write port (registered)
//   o_drop_count            saturating count of accepted out-of-range writes
module ws2812_write_arbiter #(
   parameter int unsigned NUM_LEDS = 8,
   parameter int unsigned LED_W    = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_a_valid,
   output logic             o_a_ready,
   input  logic [LED_W-1:0] i_a_led,
   input  logic [23:0]      i_a_rgb,
   input  logic             i_b_valid,
   output logic             o_b_ready,
   input  logic [LED_W-1:0] i_b_led,
   input  logic [23:0]      i_b_rgb,
   input  logic             i_fill_start,
   input  logic [23:0]      i_fill_rgb,
   output logic             o_fill_busy,
   output logic             o_ws_write,
   output logic [LED_W-1:0] o_ws_led_num,
   output logic [23:0]      o_ws_rgb_data,
   output logic [7:0]       o_drop_count
);

   // One extra bit so NUM_LEDS == 2**LED_W is representable in the range check
   localparam logic [LED_W:0]   LP_NUM  = (LED_W+1)'(NUM_LEDS);
   localparam logic [LED_W-1:0] LP_LAST = LED_W'(NUM_LEDS - 1);

   typedef enum logic {
      S_ARB  = 1'b0,
      S_FILL = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_last_b;      // 1: B was granted last tie, so A wins next
   logic [LED_W-1:0] r_idx;
   logic [23:0]      r_fill_rgb;
   logic             r_fill_busy;
   logic             r_ws_write;
   logic [LED_W-1:0] r_ws_led_num;
   logic [23:0]      r_ws_rgb_data;
   logic [7:0]       r_drop_count;

   logic             w_arb;
   logic             w_a_grant;
   logic             w_b_grant;
   logic             w_tie;
   logic [LED_W-1:0] w_sel_led;
   logic [23:0]      w_sel_rgb;
   logic             w_in_range;

   // Grant logic: fill_start beats both requesters; ties alternate
   assign w_arb      = (r_state == S_ARB) & ~i_fill_start;
   assign w_tie      = i_a_valid & i_b_valid;
   assign w_a_grant  = w_arb & i_a_valid & (~i_b_valid | r_last_b);
   assign w_b_grant  = w_arb & i_b_valid & (~i_a_valid | ~r_last_b);
   assign w_sel_led  = w_a_grant ? i_a_led : i_b_led;
   assign w_sel_rgb  = w_a_grant ? i_a_rgb : i_b_rgb;
   assign w_in_range = {1'b0, w_sel_led} < LP_NUM;

   assign o_a_ready     = w_a_grant;
   assign o_b_ready     = w_b_grant;
   assign o_fill_busy   = r_fill_busy;
   assign o_ws_write    = r_ws_write;
   assign o_ws_led_num  = r_ws_led_num;
   assign o_ws_rgb_data = r_ws_rgb_data;
   assign o_drop_count  = r_drop_count;

   // Arbitration / fill FSM with registered driver outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_ARB;
         r_last_b      <= 1'b1;
         r_idx         <= '0;
         r_fill_rgb    <= '0;
         r_fill_busy   <= 1'b0;
         r_ws_write    <= 1'b0;
         r_ws_led_num  <= '0;
         r_ws_rgb_data <= '0;
         r_drop_count  <= '0;
      end else begin
         r_ws_write <= 1'b0;
         case (r_state)
            S_ARB: begin
               if (i_fill_start) begin
                  r_ws_write    <= 1'b1;
                  r_ws_led_num  <= '0;
                  r_ws_rgb_data <= i_fill_rgb;
                  r_fill_rgb    <= i_fill_rgb;
                  r_idx         <= LED_W'(1);
                  r_fill_busy   <= 1'b1;
                  r_state       <= S_FILL;
               end else if (w_a_grant | w_b_grant) begin
                  if (w_tie) begin
                     r_last_b <= w_b_grant;
                  end
                  if (w_in_range) begin
                     r_ws_write    <= 1'b1;
                     r_ws_led_num  <= w_sel_led;
                     r_ws_rgb_data <= w_sel_rgb;
                  end else if (r_drop_count != 8'hFF) begin
                     r_drop_count <= r_drop_count + 8'd1;
                  end
               end
            end
            S_FILL: begin
               r_ws_write    <= 1'b1;
               r_ws_led_num  <= r_idx;
               r_ws_rgb_data <= r_fill_rgb;
               r_idx         <= r_idx + LED_W'(1);
               // Leave on the last LED so the next cycle can accept A/B
               if (r_idx == LP_LAST) begin
                  r_fill_busy <= 1'b0;
                  r_state     <= S_ARB;
               end
            end
            default: begin
               r_state <= S_ARB;
            end
         endcase
      end
   end

endmodule
